// File: rtl/pflink_rx_framer.sv
// Purpose: PF link RX framer - comma alignment at either byte offset, hunt/verify/locked
//          qualification, and packing of GROUP aligned words into one strobed output word.
// Latency: raw word of the last slot at cycle t -> out_stb at t+2. Backpressure: none, the GT stream cannot stall.
module pflink_rx_framer #(
  parameter int          GROUP    = 2,
  parameter logic [7:0]  COMMA    = 8'hBC,
  parameter logic [7:0]  PAD      = 8'h1C,
  parameter int          LOCK_CNT = 4,
  parameter int          LOSS_CNT = 4,
  parameter int          CNT_W    = 32
) (
  input  logic                 clk_link,
  input  logic                 reset,
  input  logic [15:0]          rx_d_i,
  input  logic [1:0]           rx_k_i,
  input  logic [1:0]           rx_nit_i,
  input  logic                 rx_rst_done,
  input  logic                 counter_reset,
  output logic [16*GROUP-1:0]  out_d,
  output logic [2*GROUP-1:0]   out_k,
  output logic                 out_stb,
  output logic                 out_v,
  output logic                 locked,
  output logic                 byte_shift,
  output logic [CNT_W-1:0]     err_count,
  output logic [15:0]          relock_count
);

  localparam int              PH_W    = (GROUP > 2) ? $clog2(GROUP) : 1;
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(GROUP - 1);
  localparam logic [3:0]      LOCK4   = 4'(LOCK_CNT);
  localparam logic [3:0]      LOSS4   = 4'(LOSS_CNT);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  // One aligned GT word with the rx_rst_done level that arrived alongside it.
  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  k;
    logic [1:0]  nit;
    logic        rdone;
  } word_t;

  state_t               state_q, state_n;
  logic [7:0]           hold_d;
  logic                 hold_k, hold_nit;
  word_t                al_q, al_n;
  logic                 al_vld;
  logic [PH_W-1:0]      phase_q, phase_cur, phase_n;
  logic [3:0]           good_q, good_n, miss_q, miss_n;
  logic                 synced_q, synced_n, shift_n, relock_inc;
  logic [16*GROUP-1:0]  grp_dat_q, grp_dat_n;
  logic [2*GROUP-1:0]   grp_k_q, grp_k_n;
  logic                 grp_err_q, grp_err_n, grp_ok_q, grp_ok_n, emit;
  logic                 raw_lo, raw_hi, al_comma, al_bad;

  // Shifted alignment takes the low byte of this word as the upper half and the held upper byte as the lower half.
  assign al_n = byte_shift
              ? word_t'{d: {rx_d_i[7:0], hold_d}, k: {rx_k_i[0], hold_k},
                        nit: {rx_nit_i[0], hold_nit}, rdone: rx_rst_done}
              : word_t'{d: rx_d_i, k: rx_k_i, nit: rx_nit_i, rdone: rx_rst_done};

  assign raw_lo   = (rx_k_i == 2'b01) && (rx_d_i[7:0] == COMMA);
  assign raw_hi   = (rx_k_i == 2'b10) && (rx_d_i[15:8] == COMMA);
  assign al_comma = al_vld && (al_q.k == 2'b01) && (al_q.d[7:0] == COMMA);
  assign al_bad   = al_vld && ((al_q.nit != 2'b00) || !al_q.rdone);

  // Outside LOCKED a comma resynchronises the slot counter; in LOCKED it must already sit at slot 0.
  assign phase_cur = (al_comma && (state_q != LOCKED)) ? '0 : phase_q;
  assign phase_n   = !al_vld ? phase_q : ((phase_cur == LAST_PH) ? '0 : phase_cur + 1'b1);
  assign locked    = (state_q == LOCKED);

  // Align stage: keep the upper byte of the previous raw word and register the aligned word.
  always_ff @(posedge clk_link) begin
    if (reset) begin
      hold_d   <= '0;
      hold_k   <= 1'b0;
      hold_nit <= 1'b0;
      al_q     <= '0;
      al_vld   <= 1'b0;
    end else begin
      hold_d   <= rx_d_i[15:8];
      hold_k   <= rx_k_i[1];
      hold_nit <= rx_nit_i[1];
      al_q     <= al_n;
      al_vld   <= 1'b1;
    end
  end

  // Lock FSM next state: HUNT scans raw bytes, VERIFY/LOCKED judge the aligned stream.
  // The first aligned comma in VERIFY is the one HUNT already counted, so it only syncs the phase.
  always_comb begin
    state_n    = state_q;
    shift_n    = byte_shift;
    good_n     = good_q;
    miss_n     = miss_q;
    synced_n   = synced_q;
    relock_inc = 1'b0;
    case (state_q)
      HUNT: begin
        if (raw_lo || raw_hi) begin
          shift_n  = !raw_lo;
          state_n  = VERIFY;
          good_n   = 4'd1;
          synced_n = 1'b0;
        end
      end
      VERIFY: begin
        if (al_bad) begin
          state_n = HUNT;
        end else if (al_comma) begin
          if (!synced_q) begin
            synced_n = 1'b1;
            if (good_q >= LOCK4) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end else if (phase_q == '0) begin
            good_n = good_q + 4'd1;
            if (good_q + 4'd1 >= LOCK4) begin
              state_n = LOCKED;
              miss_n  = '0;
            end
          end else begin
            state_n = HUNT;
          end
        end
      end
      LOCKED: begin
        if (al_comma && (phase_q != '0)) begin
          state_n    = HUNT;
          relock_inc = 1'b1;
        end else if (al_bad) begin
          miss_n = miss_q + 4'd1;
          if (miss_q + 4'd1 >= LOSS4) begin
            state_n    = HUNT;
            relock_inc = 1'b1;
          end
        end else if (al_vld) begin
          miss_n = '0;
        end
      end
      default: state_n = HUNT;
    endcase
  end

  // Group assembly: only a group opened at slot 0 while locked, and still locked at its last slot, is emitted.
  always_comb begin
    grp_dat_n = grp_dat_q;
    grp_k_n   = grp_k_q;
    grp_err_n = 1'b0;
    grp_ok_n  = 1'b0;
    emit      = 1'b0;
    if ((state_q == LOCKED) && al_vld) begin
      grp_dat_n[32'(phase_cur) * 16 +: 16] = al_q.d;
      grp_k_n[32'(phase_cur) * 2 +: 2]     = al_q.k;
      if (phase_cur == '0) begin
        grp_ok_n  = 1'b1;
        grp_err_n = al_bad;
      end else begin
        grp_ok_n  = grp_ok_q;
        grp_err_n = grp_err_q | al_bad;
      end
      emit = (phase_cur == LAST_PH) && grp_ok_n && (state_n == LOCKED);
    end
  end

  // FSM, phase and group state registers.
  always_ff @(posedge clk_link) begin
    if (reset) begin
      state_q    <= HUNT;
      byte_shift <= 1'b0;
      phase_q    <= '0;
      good_q     <= '0;
      miss_q     <= '0;
      synced_q   <= 1'b0;
      grp_dat_q  <= '0;
      grp_k_q    <= '0;
      grp_err_q  <= 1'b0;
      grp_ok_q   <= 1'b0;
    end else begin
      state_q    <= state_n;
      byte_shift <= shift_n;
      phase_q    <= phase_n;
      good_q     <= good_n;
      miss_q     <= miss_n;
      synced_q   <= synced_n;
      grp_dat_q  <= grp_dat_n;
      grp_k_q    <= grp_k_n;
      grp_err_q  <= grp_err_n;
      grp_ok_q   <= grp_ok_n;
    end
  end

  // Output register: strobe completed groups, hold between strobes, fill with PAD whenever not locked.
  always_ff @(posedge clk_link) begin
    if (reset) begin
      out_d   <= {(2*GROUP){PAD}};
      out_k   <= '1;
      out_stb <= 1'b0;
      out_v   <= 1'b0;
    end else begin
      out_stb <= emit;
      out_v   <= emit && !grp_err_n;
      if (emit) begin
        out_d <= grp_dat_n;
        out_k <= grp_k_n;
      end else if (state_n != LOCKED) begin
        out_d <= {(2*GROUP){PAD}};
        out_k <= '1;
      end
    end
  end

  // Saturating error and relock counters; counter_reset wins over a same-cycle increment.
  always_ff @(posedge clk_link) begin
    if (reset || counter_reset) begin
      err_count    <= '0;
      relock_count <= '0;
    end else begin
      if (al_bad && (err_count != '1)) err_count <= err_count + 1'b1;
      if (relock_inc && (relock_count != 16'hFFFF)) relock_count <= relock_count + 16'd1;
    end
  end

endmodule

// File: doc/pflink_rx_framer.md
Name: pflink_rx_framer

Overview:
Receive-side framer for the PF optical link. It takes the 16-bit/2-K-bit GT receive stream and finds comma alignment at either byte offset. It then packs GROUP consecutive aligned words into one output word with a per-group valid. Lock is qualified by a hunt/verify/locked state machine and tracked by saturating error and relock counters. It generalises the fixed 2-word, low-byte-comma-only packer to any group size, byte-shift recovery and hysteretic lock.

Parameters:
GROUP, 2, number of 16-bit words per output word (2..8)
COMMA, 8'hBC, K-character marking slot 0 of a group
PAD, 8'h1C, fill byte driven when not locked
LOCK_CNT, 4, consecutive correctly phased commas needed to enter LOCKED (1..15)
LOSS_CNT, 4, consecutive bad words that drop lock (1..15)
CNT_W, 32, width of err_count

Ports:
clk_link  in  1  link user clock; all logic on this clock
reset  in  1  synchronous, active-high
rx_d_i  in  16  GT receive data, byte 0 = [7:0]
rx_k_i  in  2  GT char-is-K per byte
rx_nit_i  in  2  GT not-in-table per byte
rx_rst_done  in  1  GT RX reset done; low = every word is bad
counter_reset  in  1  level; clears err_count and relock_count
out_d  out  16*GROUP  packed data, slot 0 in LSBs
out_k  out  2*GROUP  packed K flags
out_stb  out  1  one-cycle pulse per completed group
out_v  out  1  group valid, meaningful only when out_stb=1
locked  out  1  FSM in LOCKED
byte_shift  out  1  1 = comma was found in the upper byte
err_count  out  CNT_W  saturating count of bad aligned words
relock_count  out  16  saturating count of LOCKED->HUNT transitions

Behaviour:
- Reset values:
  - out_d = all PAD; out_k = all ones.
  - out_stb, out_v, locked, byte_shift = 0; err_count, relock_count = 0.
  - FSM = HUNT; phase = 0; internal hold and group registers cleared.
- Align stage (registered, 1 cycle):
  - hold the upper byte, its K and its nit from the previous cycle.
  - byte_shift=0: aligned = raw word.
  - byte_shift=1: aligned = {raw[7:0], held[15:8]}, with K and nit moved the same way.
- Bad word: aligned nit != 0, or rx_rst_done=0, sampled with that word.
- Aligned comma: aligned k == 2'b01 and aligned d[7:0] == COMMA.
- Phase counter: slot index 0..GROUP-1, wraps from GROUP-1 to 0.
  - An aligned comma in HUNT or VERIFY forces phase=0 for that word.
- FSM:
  - HUNT: watch the raw stream.
    - raw k==01 and d[7:0]==COMMA -> byte_shift<=0, go to VERIFY, good=1.
    - raw k==10 and d[15:8]==COMMA -> byte_shift<=1, go to VERIFY, good=1.
    - If both match in one cycle, the low byte wins.
  - VERIFY: watch the aligned stream.
    - comma at phase 0 -> good++; good reaching LOCK_CNT -> LOCKED, miss=0.
    - comma at phase != 0, or a bad word -> HUNT.
  - LOCKED:
    - bad word -> miss++; reaching LOSS_CNT -> HUNT.
    - good word -> miss=0.
    - comma at phase != 0 -> immediate HUNT.
    - every LOCKED->HUNT transition increments relock_count, saturating at 16'hFFFF.
  - reset takes precedence in every state.
- Packing:
  - slot p of the aligned word goes to out_d[16p+15:16p] and out_k[2p+1:2p].
  - A per-group error flag ORs the bad-word condition across all slots.
  - When the slot GROUP-1 word is aligned, the next cycle drives out_d/out_k = group, out_stb=1, out_v = locked && !err_flag.
  - Latency: raw word of the last slot at cycle t -> out_stb at t+2.
  - out_stb is emitted in LOCKED only. In any other state out_d/out_k go to PAD/ones and out_stb=0.
  - A group straddling a drop to HUNT is discarded and no strobe is issued.
  - Entering LOCKED starts with a fresh group at the next phase 0.
- err_count:
  - +1 per bad aligned word in any state; saturates at all ones.
  - counter_reset clears it; counter_reset beats a same-cycle increment.
- Reset mid-group: the partial group is dropped and no strobe is issued.

Test Plan:
1. GROUP=2: feed {d=0x12BC,k=01} then {0x3456,k=00} repeated. -> locked rises after the 4th comma. Subsequent out_stb every 2 cycles with out_d=0x345612BC, out_k=4'b0001, out_v=1, byte_shift=0.
2. Same stream delayed by one byte, so commas arrive as raw k=10, d[15:8]=BC. -> byte_shift=1, locked rises, output identical to test 1.
3. While locked, assert rx_nit_i=01 for one word. -> one group with out_v=0, err_count=1, locked stays 1. Then 4 consecutive bad words -> locked falls, relock_count=1, out_stb stops.
4. While locked, insert a comma at phase 1. -> immediate HUNT, relock_count increments, relock after 4 good commas.
5. Force err_count to all ones (rx_rst_done=0), then continue. -> holds all ones. counter_reset asserted together with a bad word -> err_count=0 next cycle.
6. Assert reset mid-group while locked. -> next cycle locked=0, out_stb=0, out_d=all 0x1C, out_k all ones, counters 0.
